// File: rtl/geometry_fetch_if.sv
// geometry_fetch_if: burst control, geometry ROM port and output stream of geometry_fetch
interface geometry_fetch_if #(parameter int WIDTH = 32);
    logic             start;
    logic [31:0]      base_addr;
    logic [15:0]      count;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    modport master (
        output start, base_addr, count, rom_data, out_ready,
        input  busy, done, err, rom_addr, out_data, out_valid, out_last
    );
    modport slave (
        input  start, base_addr, count, rom_data, out_ready,
        output busy, done, err, rom_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/geometry_fetch.sv
// geometry_fetch: streams a range-checked burst of geometry ROM words through a small credit-limited FIFO
module geometry_fetch #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    geometry_fetch_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t            state;
    logic [15:0]       cnt;
    logic [15:0]       issued;
    logic              inflight;
    logic              inflight_last;
    logic [AW:0]       fifo_count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [AW+1:0]     credit_sum;
    logic [32:0]       range_sum;
    logic              issue;
    logic              last_issue;
    logic              push;
    logic              pop;
    // Words already requested from the ROM count against FIFO space; a pop this cycle does not
    assign credit_sum = {1'b0, fifo_count} + (AW+2)'(inflight);
    assign issue      = (state == FETCH) && (credit_sum < (AW+2)'(FIFO_DEPTH));
    assign last_issue = issue && (issued == cnt - 16'd1);
    assign range_sum  = {1'b0, bus.base_addr} + {17'b0, bus.count};
    assign push       = inflight;
    assign pop        = bus.out_valid && bus.out_ready;
    assign bus.out_valid = fifo_count != '0;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.out_last  = last_mem[rd_ptr] && bus.out_valid;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rom_data;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rom_addr  <= '0;
            cnt           <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            last_mem      <= '0;
        end else begin
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            inflight      <= issue;
            inflight_last <= last_issue;
            fifo_count    <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) begin
                last_mem[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: if (bus.start) begin
                    if (range_sum > 33'(DEPTH)) bus.err <= 1'b1;
                    else if (bus.count == '0) bus.done <= 1'b1;
                    else begin
                        state        <= FETCH;
                        bus.busy     <= 1'b1;
                        bus.rom_addr <= bus.base_addr;
                        cnt          <= bus.count;
                        issued       <= '0;
                    end
                end
                FETCH: if (issue) begin
                    issued <= issued + 16'd1;
                    if (last_issue) state <= DRAIN;
                    else bus.rom_addr <= bus.rom_addr + 32'd1;
                end
                DRAIN: if (pop && last_mem[rd_ptr]) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_geometry_fetch.sv
// tb_geometry_fetch: directed bursts against a registered-read ROM model with hand-computed expectations
module tb_geometry_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    logic [31:0] dlog[$];
    bit          llog[$];
    bit   stall_en = 1'b0;
    bit   was_full = 1'b0;
    logic [31:0] held = '0;
    int   maxf = 0;
    int   nstall = 0;
    geometry_fetch_if #(.WIDTH(32)) bus ();
    geometry_fetch dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.rom_data <= 32'hA000_0000 + bus.rom_addr;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_done(input string tag, input int lim, input bit pat);
        bit got = 1'b0;
        for (int k = 0; k < lim && !got; k++) begin
            if (pat) bus.out_ready = (k % 3 == 0);
            tick();
            got = bus.done;
        end
        chk(tag, got, 1);
    endtask
    // Transfers are logged mid-cycle, when the handshake for the coming edge is settled
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            dlog.push_back(bus.out_data);
            llog.push_back(bus.out_last);
        end
        if (stall_en) begin
            if (int'(dut.fifo_count) > maxf) maxf = int'(dut.fifo_count);
            if (was_full) begin
                chk("stall_addr", bus.rom_addr, held);
                nstall++;
            end
            was_full = (dut.fifo_count == 4);
            held     = bus.rom_addr;
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.start = 0; bus.base_addr = 0; bus.count = 0; bus.out_ready = 1;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_valid", bus.out_valid, 0);
        rst = 0;
        // base=16 count=4, ready held high
        bus.base_addr = 16; bus.count = 4; bus.start = 1;
        tick(); bus.start = 0;
        chk("t1_busy_c1", bus.busy, 1);
        chk("t1_valid_c1", bus.out_valid, 0);
        chk("t1_addr_c1", bus.rom_addr, 16);
        tick();
        chk("t1_valid_c2", bus.out_valid, 0);
        chk("t1_addr_c2", bus.rom_addr, 17);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_data", bus.out_data, 32'hA000_0010 + i);
            chk("t1_last", bus.out_last, i == 3);
            chk("t1_done_early", bus.done, 0);
        end
        chk("t1_busy_c6", bus.busy, 1);
        tick();
        chk("t1_done", bus.done, 1);
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_valid_end", bus.out_valid, 0);
        chk("t1_last_end", bus.out_last, 0);
        tick();
        chk("t1_done_clear", bus.done, 0);
        // base=0 count=10, ready throttled to one cycle in three
        dlog.delete(); llog.delete();
        stall_en = 1; was_full = 0; maxf = 0; nstall = 0;
        bus.base_addr = 0; bus.count = 10; bus.start = 1;
        tick(); bus.start = 0;
        wait_done("t2_done", 100, 1);
        chk("t2_busy_end", bus.busy, 0);
        stall_en = 0; was_full = 0; bus.out_ready = 1;
        chk("t2_xfers", dlog.size(), 10);
        for (int i = 0; i < dlog.size() && i < 10; i++) chk("t2_data", dlog[i], 32'hA000_0000 + i);
        chk("t2_last", llog.size() == 10 && llog[9] == 1 && llog[8] == 0, 1);
        chk("t2_maxfifo", maxf <= 4, 1);
        chk("t2_stalled", nstall > 0, 1);
        // range overflow by one word
        tick();
        bus.base_addr = 8190; bus.count = 3; bus.start = 1;
        tick(); bus.start = 0;
        chk("t3_err", bus.err, 1);
        chk("t3_busy", bus.busy, 0);
        chk("t3_done", bus.done, 0);
        chk("t3_valid", bus.out_valid, 0);
        tick();
        chk("t3_err_clear", bus.err, 0);
        chk("t3_busy2", bus.busy, 0);
        chk("t3_valid2", bus.out_valid, 0);
        // range ending exactly at DEPTH
        dlog.delete(); llog.delete();
        bus.count = 2; bus.start = 1;
        tick(); bus.start = 0;
        chk("t3b_busy", bus.busy, 1);
        wait_done("t3b_done", 20, 0);
        chk("t3b_xfers", dlog.size(), 2);
        chk("t3b_d0", dlog.size() > 0 ? dlog[0] : 32'h0, 32'hA000_1FFE);
        chk("t3b_d1", dlog.size() > 1 ? dlog[1] : 32'h0, 32'hA000_1FFF);
        chk("t3b_l", llog.size() == 2 && llog[0] == 0 && llog[1] == 1, 1);
        // zero-length burst
        tick();
        bus.base_addr = 3; bus.count = 0; bus.start = 1;
        tick(); bus.start = 0;
        chk("t4_done", bus.done, 1);
        chk("t4_busy", bus.busy, 0);
        chk("t4_err", bus.err, 0);
        chk("t4_valid", bus.out_valid, 0);
        tick();
        chk("t4_done_clear", bus.done, 0);
        chk("t4_valid2", bus.out_valid, 0);
        // ignored restart, then reset after two transfers
        dlog.delete(); llog.delete();
        bus.base_addr = 0; bus.count = 8; bus.start = 1;
        tick(); bus.start = 0;
        tick();
        bus.base_addr = 100; bus.start = 1;
        tick(); bus.start = 0;
        chk("t5_err", bus.err, 0);
        chk("t5_addr", bus.rom_addr, 2);
        chk("t5_d0", bus.out_data, 32'hA000_0000);
        tick();
        chk("t5_d1", bus.out_data, 32'hA000_0001);
        tick();
        rst = 1; #1;
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_done", bus.done, 0);
        chk("t5_rst_err", bus.err, 0);
        chk("t5_rst_addr", bus.rom_addr, 0);
        chk("t5_rst_valid", bus.out_valid, 0);
        chk("t5_rst_last", bus.out_last, 0);
        chk("t5_xfers", dlog.size(), 2);
        tick();
        rst = 0;
        chk("t5_post_valid", bus.out_valid, 0);
        dlog.delete(); llog.delete();
        bus.base_addr = 5; bus.count = 1; bus.start = 1;
        tick(); bus.start = 0;
        wait_done("t5b_done", 20, 0);
        chk("t5b_xfers", dlog.size(), 1);
        chk("t5b_d", dlog.size() > 0 ? dlog[0] : 32'h0, 32'hA000_0005);
        chk("t5b_l", llog.size() > 0 ? llog[0] : 1'b0, 1);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
